// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts 32-bit words on valid/ready and writes them big-endian, one byte per clock.
// Latency: first byte write is presented the cycle after the handshake; one word per 5 cycles at best.
// Backpressure: InReady is high only in IDLE; the source holds its word until the loader returns to IDLE.
module imem_loader #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_finish,
  input  logic              i_in_valid,
  input  logic [31:0]       i_in_data,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_byte,
  output logic [ADDR_W-2:0] o_word_count,
  output logic              o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // base carries one extra bit so that it can reach DEPTH when DEPTH == 2^ADDR_W
  localparam int BW = ADDR_W + 1;
  localparam logic [BW-1:0] DEPTH_B = BW'(DEPTH);

  state_t            r_state;
  logic [BW-1:0]     r_base;
  logic [1:0]        r_idx;
  logic [31:0]       r_hold;
  logic              r_live;

  logic              w_accept;
  logic [1:0]        w_idx_nxt;
  logic [BW-1:0]     w_base_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [7:0]        w_byte_nxt;

  // r_live keeps InReady low until the first edge after reset release
  assign o_in_ready = r_live & (r_state == S_IDLE) & ~o_done;
  // Start wins over a simultaneous handshake: the word is not taken
  assign w_accept   = i_in_valid & o_in_ready & ~i_start;
  assign w_idx_nxt  = r_idx + 2'd1;
  assign w_base_nxt = r_base + BW'(4);
  assign w_addr_nxt = r_base[ADDR_W-1:0] + ADDR_W'(w_idx_nxt);

  // Select the next byte of the held word, MSB first
  always_comb begin
    w_byte_nxt = r_hold[31:24];
    case (w_idx_nxt)
      2'd0:    w_byte_nxt = r_hold[31:24];
      2'd1:    w_byte_nxt = r_hold[23:16];
      2'd2:    w_byte_nxt = r_hold[15:8];
      default: w_byte_nxt = r_hold[7:0];
    endcase
  end

  // Loader FSM with registered write-port outputs and word bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_idx        <= '0;
      r_hold       <= '0;
      r_live       <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_byte    <= '0;
      o_word_count <= '0;
      o_done       <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (i_start) begin
        // Abandon any word in flight; bytes already written stay in memory
        r_state      <= S_IDLE;
        r_base       <= '0;
        r_idx        <= '0;
        o_wr_en      <= 1'b0;
        o_word_count <= '0;
        o_done       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_hold    <= i_in_data;
              r_idx     <= 2'd0;
              o_wr_en   <= 1'b1;
              o_wr_addr <= r_base[ADDR_W-1:0];
              o_wr_byte <= i_in_data[31:24];
              r_state   <= S_WRITE;
            end else if (i_finish) begin
              r_state <= S_DONE;
              o_done  <= 1'b1;
            end
          end
          S_WRITE: begin
            if (r_idx == 2'd3) begin
              o_wr_en      <= 1'b0;
              r_base       <= w_base_nxt;
              o_word_count <= o_word_count + (ADDR_W-1)'(1);
              // Stop at the memory boundary so no write can reach DEPTH
              if (w_base_nxt == DEPTH_B) begin
                r_state <= S_DONE;
                o_done  <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_idx     <= w_idx_nxt;
              o_wr_addr <= w_addr_nxt;
              o_wr_byte <= w_byte_nxt;
            end
          end
          S_DONE: begin
            o_wr_en <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            o_wr_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single words, start/finish handling, full fill and async reset.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        finish;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_byte;
  logic [5:0]  word_count;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  imem_loader #(.ADDR_W(7), .DEPTH(128)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_finish     (finish),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_byte    (wr_byte),
    .o_word_count (word_count),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present w, wait (bounded) for acceptance, then check the four byte writes at a..a+3.
  // Leaves in_valid high; the caller decides what the source does next.
  task automatic send_check(input logic [31:0] w, input logic [6:0] a, input string tag);
    int n;
    logic [31:0] eb;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_data = ~w;
    for (int b = 0; b < 4; b++) begin
      eb = (w >> (24 - 8 * b)) & 32'hFF;
      chk({tag, ".en"},   {31'd0, wr_en}, 32'd1);
      chk({tag, ".addr"}, {25'd0, wr_addr}, {25'd0, a + 7'(b)});
      chk({tag, ".byte"}, {24'd0, wr_byte}, eb);
      chk({tag, ".busy"}, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    chk({tag, ".idle"}, {31'd0, wr_en}, 32'd0);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n    = 1'b0;
    start    = 1'b0;
    finish   = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;

    // Reset state
    #1;
    chk("rst.en",    {31'd0, wr_en}, 32'd0);
    chk("rst.done",  {31'd0, done}, 32'd0);
    chk("rst.rdy",   {31'd0, in_ready}, 32'd0);
    chk("rst.addr",  {25'd0, wr_addr}, 32'd0);
    chk("rst.byte",  {24'd0, wr_byte}, 32'd0);
    chk("rst.wc",    {26'd0, word_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.rdy0",  {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("rel.rdy1",  {31'd0, in_ready}, 32'd1);

    // Single word, big-endian byte order
    send_check(32'h8C010004, 7'd0, "w1");
    in_valid = 1'b0;
    chk("w1.wc",  {26'd0, word_count}, 32'd1);
    chk("w1.rdy", {31'd0, in_ready}, 32'd1);

    // Start together with a handshake: word refused, then re-presented at address 0
    in_valid = 1'b1;
    in_data  = 32'h11223344;
    pulse_start();
    chk("sv.en", {31'd0, wr_en}, 32'd0);
    chk("sv.wc", {26'd0, word_count}, 32'd0);
    send_check(32'h11223344, 7'd0, "sv");
    in_valid = 1'b0;
    chk("sv.wc1", {26'd0, word_count}, 32'd1);

    // Start during byte index 2 of the next word (at base 4)
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ab.a0", {25'd0, wr_addr}, 32'd4);
    @(negedge clk);
    @(negedge clk);
    chk("ab.a2", {25'd0, wr_addr}, 32'd6);
    chk("ab.b2", {24'd0, wr_byte}, 32'hBE);
    pulse_start();
    chk("ab.en", {31'd0, wr_en}, 32'd0);
    chk("ab.wc", {26'd0, word_count}, 32'd0);
    chk("ab.rdy", {31'd0, in_ready}, 32'd1);
    send_check(32'hCAFEF00D, 7'd0, "ab");
    in_valid = 1'b0;

    // Three words then Finish in IDLE
    send_check(32'h01020304, 7'd4, "f2");
    send_check(32'hA5B6C7D8, 7'd8, "f3");
    in_valid = 1'b0;
    finish   = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    chk("fin.done", {31'd0, done}, 32'd1);
    chk("fin.rdy",  {31'd0, in_ready}, 32'd0);
    chk("fin.wc",   {26'd0, word_count}, 32'd3);
    in_valid = 1'b1;
    in_data  = 32'h55555555;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wr_en) cnt++;
    end
    in_valid = 1'b0;
    chk("fin.nowr", cnt, 32'd0);
    pulse_start();
    chk("fin.done0", {31'd0, done}, 32'd0);
    chk("fin.wc0",   {26'd0, word_count}, 32'd0);
    send_check(32'h0BADF00D, 7'd0, "fs");
    in_valid = 1'b0;

    // Fill the whole memory back-to-back; byte at address a carries value a
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      send_check({8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)}, 7'(4 * i), "full");
    end
    chk("full.done", {31'd0, done}, 32'd1);
    chk("full.rdy",  {31'd0, in_ready}, 32'd0);
    chk("full.wc",   {26'd0, word_count}, 32'd32);
    in_data = 32'hFFFFFFFF;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_en || in_ready) cnt++;
    end
    in_valid = 1'b0;
    chk("full.no33", cnt, 32'd0);
    chk("full.wc2",  {26'd0, word_count}, 32'd32);

    // Async reset while Done is high
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar1.done", {31'd0, done}, 32'd0);
    chk("ar1.wc",   {26'd0, word_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Async reset in the middle of a word, then reload from address 0
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ar2.en1", {31'd0, wr_en}, 32'd1);
    chk("ar2.a1",  {25'd0, wr_addr}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar2.en",   {31'd0, wr_en}, 32'd0);
    chk("ar2.done", {31'd0, done}, 32'd0);
    chk("ar2.rdy",  {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_check(32'h9ABCDEF0, 7'd0, "ar2");
    in_valid = 1'b0;
    chk("ar2.wc", {26'd0, word_count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-addressed instruction memory: takes 32-bit instruction words over a valid/ready handshake and writes them into the memory's byte write port, one byte per clock.
- Byte order is big-endian: the word's MSB lands at the lowest address, matching the fetch path (addr+0 = bits 31:24 … addr+3 = bits 7:0).
- Sits between the program-download source (test bench / UART / boot ROM) and the instruction memory write port; the CPU is held off until Done.

Parameters:
- ADDR_W, 7, byte-address width of the instruction memory.
- DEPTH, 128, memory size in bytes; must be a multiple of 4 and ≤ 2^ADDR_W.

Ports:
- CLK  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  synchronous pulse: restart the load at address 0, aborting any word in flight.
- Finish  input  1  synchronous pulse: end the load early; accepted only in IDLE.
- InValid  input  1  source has a word on InData.
- InData  input  32  instruction word.
- InReady  output  1  loader can accept a word this cycle.
- WrEn  output  1  byte write strobe to the instruction memory.
- WrAddr  output  ADDR_W  byte address for the write.
- WrByte  output  8  byte data for the write.
- WordCount  output  ADDR_W-1  number of complete words written since the last Start or reset.
- Done  output  1  load finished: memory full, or Finish seen; CPU may fetch.

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE, base address=0, byte index=0, WordCount=0.
  - WrEn=0, WrAddr=0, WrByte=0, Done=0, InReady=0 while Reset is low.
  - InReady rises on the first clock edge after release.
- States:
  - IDLE: InReady=1, WrEn=0. Handshake (InValid&InReady at a rising edge) latches InData into a 32-bit holding register and moves to WRITE with byte index=0. Finish in IDLE (no handshake) → DONE.
  - WRITE: InReady=0, WrEn=1 for exactly 4 consecutive cycles.
    - WrAddr = base + index; WrByte = hold[31-8*index -: 8].
    - Index increments every cycle.
    - After index 3: base += 4, WordCount += 1. Then base==DEPTH → DONE, else IDLE.
    - Finish is ignored during WRITE.
  - DONE: Done=1, InReady=0, WrEn=0. Stays until Start or reset.
- Throughput: one word per 5 cycles (1 accept + 4 writes); a back-to-back source sees InReady high every 5th cycle.
- Latency: the first byte write is the cycle after the handshake.
- Start (any state):
  - Next edge: base=0, index=0, WordCount=0, Done=0, state=IDLE, WrEn=0.
  - A partially written word is abandoned; its already-written bytes stay in memory.
  - Start and a handshake in the same cycle: Start wins and the word is NOT accepted (source must re-present it).
- Start and Finish together: Start wins.
- Wrap: base never wraps; the DEPTH boundary forces DONE, so no write ever targets an address ≥ DEPTH.
- InData is sampled only at the handshake; later changes on InData do not affect bytes in flight.
- All outputs are registered except InReady, which decodes state (IDLE & ~Done).

Test Plan:
- Reset, then one word 0x8C010004 → WrEn high 4 cycles at WrAddr 0,1,2,3 with WrByte 0x8C,0x01,0x00,0x04; WordCount=1; InReady back high on cycle 5.
- InValid held high with 32 distinct words (DEPTH=128) → 128 byte writes, last at WrAddr 127; Done=1 after the 32nd word; InReady stays 0; a 33rd word is never accepted.
- Load 3 words, pulse Finish in IDLE → Done=1, WordCount=3, no further writes; then Start → Done=0, WordCount=0, next word writes at address 0.
- Start asserted during byte index 2 of word 1 → WrEn drops next cycle, base=0; next accepted word writes at 0..3.
- Reset pulled low mid-WRITE, asynchronous to CLK → WrEn, Done and InReady go to 0 immediately; after release, loading restarts at address 0.
- Start and InValid asserted in the same cycle in IDLE → word not accepted, no WrEn; re-presented word writes at address 0.
